// File: rtl/tmds_channel_encoder.sv
// One DVI/HDMI TMDS channel: 8b/10b DC-balanced encoder, two-stage pipeline.
// Define TMDS_OUT_REG_EN to add an output register (latency 3 instead of 2).
module tmds_channel_encoder #(
    parameter logic [1:0] RST_CD = 2'b00
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic       vde,
    input  logic [1:0] cd,
    input  logic [7:0] din,
    output logic [9:0] tmds_o
);

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    logic              vde_q;
    logic [1:0]        cd_q;
    logic [7:0]        din_q;
    logic [3:0]        n1_q;
    logic [9:0]        tmds_q;
    logic [9:0]        tmds_d;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    logic [8:0]        qm;
    logic [3:0]        n1_qm;
    logic signed [4:0] diff;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            vde_q <= 1'b0;
            cd_q  <= RST_CD;
            din_q <= '0;
            n1_q  <= '0;
        end else begin
            vde_q <= vde;
            cd_q  <= cd;
            din_q <= din;
            n1_q  <= ones8(din);
        end
    end

    always_comb begin
        logic       use_xnor;
        logic [8:0] acc;
        use_xnor = (n1_q > 4'd4) || ((n1_q == 4'd4) && !din_q[0]);
        acc      = '0;
        acc[0]   = din_q[0];
        for (int unsigned i = 1; i < 8; i++) begin
            acc[i] = use_xnor ? ~(acc[i-1] ^ din_q[i]) : (acc[i-1] ^ din_q[i]);
        end
        acc[8] = ~use_xnor;
        qm     = acc;
    end

    // N1-N0 of q_m[7:0] is 2*N1-8; the 5-bit wrap of 2*8 still yields +8.
    assign n1_qm = ones8(qm[7:0]);
    assign diff  = $signed({n1_qm, 1'b0}) - 5'sd8;

    always_comb begin
        tmds_d = ctrl_sym(cd_q);
        cnt_d  = '0;
        if (vde_q) begin
            if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
                tmds_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt_d  = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                         ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
                tmds_d = {1'b1, qm[8], ~qm[7:0]};
                cnt_d  = cnt_q + (qm[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                tmds_d = {1'b0, qm[8], qm[7:0]};
                cnt_d  = cnt_q + diff - (qm[8] ? 5'sd0 : 5'sd2);
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            tmds_q <= ctrl_sym(RST_CD);
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef TMDS_OUT_REG_EN
    logic [9:0] out_q;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            out_q <= ctrl_sym(RST_CD);
        end else begin
            out_q <= tmds_q;
        end
    end

    assign tmds_o = out_q;
`else
    assign tmds_o = tmds_q;
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder; expected symbols queued at drive time.
// Honours TMDS_OUT_REG_EN for the pipeline latency.
module tb_tmds_channel_encoder;

`ifdef TMDS_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [9:0] SYM00 = 10'b1101010100;

    logic       pixclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       vde    = 1'b0;
    logic [1:0] cd     = 2'b00;
    logic [7:0] din    = 8'h00;
    logic [9:0] tmds_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_cnt   = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_v;

    tmds_channel_encoder #(.RST_CD(2'b00)) dut (
        .pixclk(pixclk),
        .rst_n (rst_n),
        .vde   (vde),
        .cd    (cd),
        .din   (din),
        .tmds_o(tmds_o)
    );

    always #5 pixclk = ~pixclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference encoder: q_m via prefix parity, disparity from ones counts.
    task automatic model(input logic v, input logic [1:0] c, input logic [7:0] d,
                         output logic [9:0] sym);
        logic [7:0] q;
        logic       p, xn, q8;
        int         ones, zeros, n;
        if (!v) begin
            m_cnt = 0;
            case (c)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
        end else begin
            n  = $countones(d);
            xn = (n > 4) || (n == 4 && !d[0]);
            p  = 1'b0;
            for (int i = 0; i < 8; i++) begin
                p    = p ^ d[i];
                q[i] = p ^ (xn && (i % 2 == 1));
            end
            q8    = !xn;
            ones  = $countones(q);
            zeros = 8 - ones;
            if (m_cnt == 0 || ones == zeros) begin
                sym   = {~q8, q8, q8 ? q : ~q};
                m_cnt = m_cnt + (q8 ? ones - zeros : zeros - ones);
            end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
                sym   = {1'b1, q8, ~q};
                m_cnt = m_cnt + (q8 ? 2 : 0) + zeros - ones;
            end else begin
                sym   = {1'b0, q8, q};
                m_cnt = m_cnt + ones - zeros - (q8 ? 0 : 2);
            end
        end
    endtask

    task automatic push_cycle(input logic v, input logic [1:0] c, input logic [7:0] d,
                              input logic use_k, input logic [9:0] k);
        logic [9:0] m;
        @(negedge pixclk);
        rst_n = 1'b1;
        vde   = v;
        cd    = c;
        din   = d;
        model(v, c, d, m);
        sb.push_back(use_k ? k : m);
        @(posedge pixclk);
        #1;
    endtask

    task automatic restart_queue();
        sb.delete();
        m_cnt = 0;
        for (int i = 0; i < LAT - 1; i++) sb.push_back(SYM00);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge pixclk);
            rst_n = 1'b0;
            vde   = 1'($urandom);
            cd    = 2'($urandom);
            din   = 8'($urandom);
            @(posedge pixclk);
            #1;
            n_tests++;
            if (tmds_o !== SYM00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, tmds_o, SYM00);
            end
        end
        restart_queue();
        for (int i = 0; i < 4; i++) begin
            push_cycle(1'b0, 2'b00, 8'h00, 1'b1, SYM00);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got %b expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL reset_release[%0d]: got %b expected %b", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_control();
        logic [9:0] k[6];
        logic [1:0] c[6];
        k = '{10'b0010101011, 10'b0101010100, 10'b1010101011, SYM00, SYM00, SYM00};
        c = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            push_cycle(1'b0, c[i], 8'($urandom), 1'b1, k[i]);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL control[%0d]: got %b expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL control[%0d]: got %b expected %b", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_zeros();
        logic [9:0] k[8];
        k = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) push_cycle(1'b1, 2'($urandom), 8'h00, 1'b1, k[i]);
            else       push_cycle(1'b0, 2'b00, 8'h00, 1'b1, SYM00);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL zeros[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL zeros[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 2 + LAT; i++) begin
            if (i == 0)      push_cycle(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200);
            else if (i == 1) push_cycle(1'b1, 2'b00, 8'hFF, 1'b0, '0);
            else             push_cycle(1'b0, 2'b00, 8'h00, 1'b1, SYM00);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ones[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL ones[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_blank_gap();
        logic [9:0] k[5];
        logic       v[5];
        k = '{10'h100, 10'h3FF, 10'h100, 10'h354, 10'h100};
        v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5 + LAT; i++) begin
            if (i < 5) push_cycle(v[i], 2'b00, 8'h00, 1'b1, k[i]);
            else       push_cycle(1'b0, 2'b00, 8'h00, 1'b1, SYM00);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL blank_gap[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL blank_gap[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            push_cycle(1'b1, 2'b00, 8'($urandom), 1'b0, '0);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL mid_reset_pre[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL mid_reset_pre[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
        @(negedge pixclk);
        rst_n = 1'b0;
        vde   = 1'b1;
        din   = 8'($urandom);
        @(posedge pixclk);
        #1;
        n_tests++;
        if (tmds_o !== SYM00) begin
            n_fail++;
            $display("FAIL mid_reset_pulse: got %h expected %h", tmds_o, SYM00);
        end
        restart_queue();
        for (int i = 0; i < 1 + LAT; i++) begin
            if (i == 0) push_cycle(1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
            else        push_cycle(1'b0, 2'b00, 8'h00, 1'b1, SYM00);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL mid_reset_post[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL mid_reset_post[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v;
        for (int i = 0; i < 300 + LAT; i++) begin
            v = (i < 300) ? ($urandom_range(0, 9) != 0) : 1'b0;
            push_cycle(v, 2'($urandom), 8'($urandom), 1'b0, '0);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected queued symbol", i, tmds_o);
            end else begin
                exp_v = sb.pop_front();
                if (tmds_o !== exp_v) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: got %h expected %h", i, tmds_o, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_control();
        test_zeros();
        test_ones();
        test_blank_gap();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
